// File: rtl/button_pkg.sv
// Register map and field layout for the push-button controller.
package button_pkg;

   localparam logic [1:0] REG_STATE  = 2'd0;
   localparam logic [1:0] REG_RISE   = 2'd1;
   localparam logic [1:0] REG_FALL   = 2'd2;
   localparam logic [1:0] REG_IRQ_EN = 2'd3;

   localparam int IRQ_EN_RISE_LSB = 0;
   localparam int IRQ_EN_FALL_LSB = 16;

   function automatic logic [31:0] lane_mask(input logic [3:0] m);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         r[8*b +: 8] = {8{m[b]}};
      end
      return r;
   endfunction

endpackage

// File: rtl/debounce.sv
// One button: 2-flop synchroniser plus stable-level debounce counter.
// rise_out/fall_out pulse combinationally on the edge stable_out updates.
module debounce #(
   parameter int DEBOUNCE = 36000
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic stable_out,
   output logic rise_out,
   output logic fall_out
);

   localparam int CW = $clog2(DEBOUNCE);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic accept;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q   <= 1'b0;
         sync_q   <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         meta_q   <= meta_d;
         sync_q   <= sync_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      meta_d   = in;
      sync_d   = meta_q;
      stable_d = stable_q;
      cnt_d    = '0;
      accept   = 1'b0;
      // Any sample matching the old level drops the count back to 0.
      if (sync_q != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            accept   = 1'b1;
            stable_d = sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign stable_out = stable_q;
   assign rise_out   = accept & sync_q;
   assign fall_out   = accept & ~sync_q;

endmodule

// File: rtl/button_ctrl.sv
// Bus-mapped button block: debounced state, sticky W1C edge flags,
// per-edge interrupt enables and a registered level interrupt.
module button_ctrl
   import button_pkg::*;
#(
   parameter int BUTTONCOUNT = 4,
   parameter int DEBOUNCE    = 36000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [BUTTONCOUNT-1:0] buttons_in,
   input  logic [31:0]            address_in,
   input  logic                   sel_in,
   input  logic                   read_in,
   output logic [31:0]            read_value_out,
   input  logic [3:0]             write_mask_in,
   input  logic [31:0]            write_value_in,
   output logic                   ready_out,
   output logic                   irq_out
);

   localparam int BC = BUTTONCOUNT;
   localparam int RL = IRQ_EN_RISE_LSB;
   localparam int FL = IRQ_EN_FALL_LSB;

   logic [BC-1:0] stable;
   logic [BC-1:0] rise_set, fall_set;
   logic [BC-1:0] rise_q, rise_d;
   logic [BC-1:0] fall_q, fall_d;
   logic [BC-1:0] en_rise_q, en_rise_d;
   logic [BC-1:0] en_fall_q, en_fall_d;
   logic          irq_q, irq_d;
   logic [31:0]   bmask;
   logic [BC-1:0] clr;
   logic          unused_bits;

   for (genvar i = 0; i < BC; i++) begin : g_btn
      debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
         .clk       (clk),
         .reset     (reset),
         .in        (buttons_in[i]),
         .stable_out(stable[i]),
         .rise_out  (rise_set[i]),
         .fall_out  (fall_set[i])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rise_q    <= '0;
         fall_q    <= '0;
         en_rise_q <= '0;
         en_fall_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         en_rise_q <= en_rise_d;
         en_fall_q <= en_fall_d;
         irq_q     <= irq_d;
      end
   end

   always_comb begin
      bmask     = lane_mask(write_mask_in);
      clr       = write_value_in[BC-1:0] & bmask[BC-1:0];
      rise_d    = rise_q;
      fall_d    = fall_q;
      en_rise_d = en_rise_q;
      en_fall_d = en_fall_q;
      if (sel_in) begin
         unique case (address_in[3:2])
            REG_RISE:   rise_d = rise_q & ~clr;
            REG_FALL:   fall_d = fall_q & ~clr;
            REG_IRQ_EN: begin
               en_rise_d = (en_rise_q & ~bmask[RL +: BC])
                         | (write_value_in[RL +: BC] & bmask[RL +: BC]);
               en_fall_d = (en_fall_q & ~bmask[FL +: BC])
                         | (write_value_in[FL +: BC] & bmask[FL +: BC]);
            end
            default: ;
         endcase
      end
      // A new edge beats a same-cycle clear.
      rise_d = rise_d | rise_set;
      fall_d = fall_d | fall_set;
      irq_d  = |((rise_q & en_rise_q) | (fall_q & en_fall_q));
   end

   always_comb begin
      read_value_out = '0;
      if (sel_in) begin
         unique case (address_in[3:2])
            REG_STATE:  read_value_out[BC-1:0] = stable;
            REG_RISE:   read_value_out[BC-1:0] = rise_q;
            REG_FALL:   read_value_out[BC-1:0] = fall_q;
            REG_IRQ_EN: begin
               read_value_out[RL +: BC] = en_rise_q;
               read_value_out[FL +: BC] = en_fall_q;
            end
            default: ;
         endcase
      end
   end

   assign ready_out = sel_in;
   assign irq_out   = irq_q;

   assign unused_bits = ^{read_in, address_in[31:4], address_in[1:0],
                          write_value_in, bmask};

endmodule

// File: tb/tb_button_ctrl.sv
// Randomised scoreboard bench for button_ctrl (4 buttons, debounce 4).
module tb_button_ctrl;

   localparam int BC = 4;
   localparam int DB = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [BC-1:0] buttons_in;
   logic [31:0]   address_in;
   logic          sel_in;
   logic          read_in;
   logic [31:0]   read_value_out;
   logic [3:0]    write_mask_in;
   logic [31:0]   write_value_in;
   logic          ready_out;
   logic          irq_out;

   int checks = 0;
   int passed = 0;

   logic [31:0] rd_q[$];
   logic        irq_q[$];

   // Reference: pin sample history, accepted levels, flags, enables.
   logic [BC-1:0] m_hist[$];
   logic [BC-1:0] m_stable = '0;
   logic [BC-1:0] m_rise = '0;
   logic [BC-1:0] m_fall = '0;
   logic [BC-1:0] m_enr = '0;
   logic [BC-1:0] m_enf = '0;
   logic          m_irq = 1'b0;

   always #5 clk = ~clk;

   button_ctrl #(.BUTTONCOUNT(BC), .DEBOUNCE(DB)) dut (
      .clk           (clk),
      .reset         (reset),
      .buttons_in    (buttons_in),
      .address_in    (address_in),
      .sel_in        (sel_in),
      .read_in       (read_in),
      .read_value_out(read_value_out),
      .write_mask_in (write_mask_in),
      .write_value_in(write_value_in),
      .ready_out     (ready_out),
      .irq_out       (irq_out)
   );

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h at %0t",
                    nm, act, exp, $time);
   endtask

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0:    return 32'(m_stable);
         2'd1:    return 32'(m_rise);
         2'd2:    return 32'(m_fall);
         default: return 32'(m_enr) | (32'(m_enf) << 16);
      endcase
   endfunction

   task automatic m_clear();
      m_hist.delete();
      repeat (DB + 2) m_hist.push_back('0);
      m_stable = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_enr    = '0;
      m_enf    = '0;
      m_irq    = 1'b0;
   endtask

   // One clock edge: a level is accepted once the synchronised pin has
   // shown the same new value for DB consecutive samples.
   task automatic m_edge(input logic [BC-1:0] pins, input logic sel,
                         input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] wv);
      logic [31:0]   bm, en32;
      logic [BC-1:0] rs, fs, clr;
      logic          nirq, same;
      nirq = |((m_rise & m_enr) | (m_fall & m_enf));
      m_hist.push_back(pins);
      void'(m_hist.pop_front());
      rs = '0;
      fs = '0;
      for (int i = 0; i < BC; i++) begin
         same = 1'b1;
         for (int k = 1; k < DB; k++)
            if (m_hist[k][i] != m_hist[0][i]) same = 1'b0;
         if (same && m_hist[0][i] != m_stable[i]) begin
            if (m_hist[0][i]) rs[i] = 1'b1;
            else fs[i] = 1'b1;
            m_stable[i] = m_hist[0][i];
         end
      end
      for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{mask[b]}};
      clr = BC'(wv & bm);
      if (sel) begin
         if (addr[3:2] == 2'd1) m_rise = m_rise & ~clr;
         if (addr[3:2] == 2'd2) m_fall = m_fall & ~clr;
         if (addr[3:2] == 2'd3) begin
            en32  = m_read(2'd3);
            en32  = (en32 & ~bm) | (wv & bm);
            m_enr = en32[BC-1:0];
            m_enf = en32[16 +: BC];
         end
      end
      m_rise = m_rise | rs;
      m_fall = m_fall | fs;
      m_irq  = nirq;
   endtask

   task automatic cycle(input logic rst, input logic [BC-1:0] pins,
                        input logic sel, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] wv);
      @(negedge clk);
      reset          = ~rst;
      buttons_in     = pins;
      sel_in         = sel & ~rst;
      read_in        = sel & ~rst;
      address_in     = addr;
      write_mask_in  = mask;
      write_value_in = wv;
      if (rst) m_clear();
      irq_q.push_back(m_irq);
      if (sel_in) rd_q.push_back(m_read(addr[3:2]));
      if (!rst) m_edge(pins, sel_in, addr, mask, wv);
   endtask

   task automatic rd(input logic [BC-1:0] p, input logic [31:0] a);
      cycle(1'b0, p, 1'b1, a, 4'h0, $urandom);
   endtask

   task automatic wr(input logic [BC-1:0] p, input logic [31:0] a,
                     input logic [3:0] m, input logic [31:0] v);
      cycle(1'b0, p, 1'b1, a, m, v);
   endtask

   initial begin : monitor
      logic        ei;
      logic [31:0] er;
      forever begin
         @(negedge clk);
         #2;
         if (irq_q.size() != 0) begin
            ei = irq_q.pop_front();
            check("irq", 32'(irq_out), 32'(ei));
         end
         if (ready_out) begin
            if (rd_q.size() == 0) begin
               checks++;
               $display("FAIL ready: ready_out=1 with no pending read");
            end else begin
               er = rd_q.pop_front();
               check("read", read_value_out, er);
            end
         end else begin
            check("idle_read", read_value_out, 32'h0);
         end
      end
   end

   initial begin : stim
      logic [BC-1:0] p;
      logic [31:0]   a;
      reset = 1'b0;
      buttons_in = '0;
      sel_in = 1'b0;
      read_in = 1'b0;
      address_in = '0;
      write_mask_in = '0;
      write_value_in = '0;
      m_clear();
      p = '0;
      repeat (2) cycle(1'b1, p, 1'b0, 0, 0, 0);
      for (int r = 0; r < 4; r++) rd(p, 32'(r * 4));
      // clean press with rise enable
      wr(p, 32'hC, 4'hF, 32'h1);
      p[0] = 1'b1;
      repeat (8) rd(p, 32'h4);
      // bounce on pin 2
      p[2] = 1'b1; rd(p, 0); rd(p, 0);
      p[2] = 1'b0; rd(p, 0); rd(p, 0);
      p[2] = 1'b1;
      repeat (10) rd(p, 32'h4);
      // write-1-to-clear, masked write, STATE write
      wr(p, 32'h4, 4'h1, 32'h1);
      wr(p, 32'h4, 4'h0, 32'hF);
      wr(p, 32'h0, 4'hF, 32'hF);
      rd(p, 32'h4);
      rd(p, 32'h0);
      // release with fall enable, then unselected read
      wr(p, 32'hC, 4'hF, 32'h0001_0000);
      p[0] = 1'b0;
      repeat (8) rd(p, 32'h8);
      cycle(1'b0, p, 1'b0, 32'h8, 4'h0, 0);
      // clear colliding with a new accepted rise
      wr(p, 32'hC, 4'hF, 32'h1);
      p[0] = 1'b1;
      repeat (8) rd(p, 32'h4);
      p[0] = 1'b0;
      repeat (8) rd(p, 32'h8);
      p[0] = 1'b1;
      repeat (DB + 2) wr(p, 32'h4, 4'h1, 32'h1);
      repeat (3) rd(p, 32'h4);
      // reset in the middle of a count, button held through it
      p = 4'h8;
      repeat (3) rd(p, 32'h0);
      repeat (2) cycle(1'b1, p, 1'b0, 0, 0, 0);
      for (int r = 0; r < 4; r++) rd(p, 32'(r * 4));
      repeat (8) rd(p, 32'h4);
      // random traffic
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < BC; i++)
            if ($urandom_range(0, 9) == 0) p[i] = ~p[i];
         a = $urandom;
         if ($urandom_range(0, 299) == 0)
            cycle(1'b1, p, 1'b0, a, 0, 0);
         else if ($urandom_range(0, 2) == 0)
            wr(p, a, 4'($urandom), $urandom);
         else
            cycle(1'b0, p, 1'($urandom), a, 4'h0, $urandom);
      end
      cycle(1'b0, p, 1'b0, 0, 0, 0);
      @(negedge clk);
      #5;
      checks++;
      if (rd_q.size() == 0 && irq_q.size() == 0) passed++;
      else $display("FAIL drain: rd_q=%0d irq_q=%0d left, expected 0",
                    rd_q.size(), irq_q.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
